uart_tx_ctrl: RTL and testbench

Bus-facing controller that schedules the UART transmitter. It takes byte writes and register accesses from the host CPU bus (addr/rw/cs already reduced to single-cycle strobes). It buffers outgoing bytes in a small FIFO. It sequences them into the transmitter through its `data`/`latch_data`/`busy` handshake, one byte per frame. It sits between the bus strobe logic and the TX shift register in the top level, and replaces the direct chip-select-to-latch connection.

---
 rtl/uart_tx_ctrl_if.sv | 20 ++
 rtl/uart_tx_ctrl.sv | 93 +++++++++
 tb/tb_uart_tx_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: host bus strobes plus transmitter load/busy handshake
interface uart_tx_ctrl_if;
  logic [1:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_wr;
  logic       bus_rd;
  logic [7:0] bus_rdata;
  logic       irq;
  logic [7:0] tx_data;
  logic       tx_latch;
  logic       tx_busy;
  modport master (
    output bus_addr, bus_wdata, bus_wr, bus_rd, tx_busy,
    input  bus_rdata, irq, tx_data, tx_latch
  );
  modport slave (
    input  bus_addr, bus_wdata, bus_wr, bus_rd, tx_busy,
    output bus_rdata, irq, tx_data, tx_latch
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: bus-fed byte FIFO that sequences frames into the UART transmitter
module uart_tx_ctrl #(
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  uart_tx_ctrl_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACCEPT, WAIT_DONE} state_t;
  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    wait_cnt, wait_cnt_n;
  logic          overflow, enable, irq_en;
  logic          full, empty, push, push_ok, load, flush, ctrl_wr, clr_wr;
  logic [7:0]    status, rd_val;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign push    = bus.bus_wr && bus.bus_addr == 2'd0;
  assign push_ok = push && !full;
  assign ctrl_wr = bus.bus_wr && bus.bus_addr == 2'd2;
  assign clr_wr  = bus.bus_wr && bus.bus_addr == 2'd3;
  assign flush   = ctrl_wr && bus.bus_wdata[7];
  assign status  = {4'(count), overflow, bus.tx_busy, full, empty};
  assign rd_val  = (bus.bus_addr == 2'd1) ? status :
                   (bus.bus_addr == 2'd2) ? {6'd0, irq_en, enable} : 8'd0;
  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    load       = 1'b0;
    case (state)
      IDLE: begin
        load    = enable && !empty && !bus.tx_busy;
        state_n = load ? LOAD : IDLE;
      end
      LOAD: begin
        state_n    = WAIT_ACCEPT;
        wait_cnt_n = '0;
      end
      WAIT_ACCEPT: begin
        // a transmitter that never accepts must not wedge the queue
        state_n    = bus.tx_busy ? WAIT_DONE : (wait_cnt == 2'd3) ? IDLE : WAIT_ACCEPT;
        wait_cnt_n = wait_cnt + 2'd1;
      end
      WAIT_DONE: state_n = bus.tx_busy ? WAIT_DONE : IDLE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= bus.bus_wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      enable        <= 1'b1;
      irq_en        <= 1'b0;
      bus.bus_rdata <= 8'd0;
      bus.tx_data   <= 8'd0;
      bus.tx_latch  <= 1'b0;
      bus.irq       <= 1'b0;
    end else begin
      state        <= state_n;
      wait_cnt     <= wait_cnt_n;
      bus.tx_latch <= load;
      if (load) bus.tx_data <= mem[rd_ptr];
      // flush wins over any push/pop bookkeeping; a byte popped now still goes out
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PW'(1);
        if (load) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push_ok) - CW'(load);
      end
      if (clr_wr) overflow <= 1'b0;
      else if (push && full) overflow <= 1'b1;
      if (ctrl_wr) begin
        enable <= bus.bus_wdata[0];
        irq_en <= bus.bus_wdata[1];
      end
      if (bus.bus_rd) bus.bus_rdata <= rd_val;
      bus.irq <= irq_en && empty && state == IDLE && !bus.tx_busy;
    end
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed and randomized checks of uart_tx_ctrl against a queue model
module tb_uart_tx_ctrl;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  uart_tx_ctrl_if bus();
  uart_tx_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fall_cyc = -100;
  int viol = 0;
  int left = 0;
  int frame_len = 6;
  logic busy_r = 1'b0;
  logic prev_latch = 1'b0;
  logic accept = 1'b1;
  logic [7:0] got[$];
  int got_cyc[$];
  assign bus.tx_busy = busy_r;
  // transmitter stub: busy for frame_len cycles after each accepted latch
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_latch <= bus.tx_latch;
    if (bus.tx_latch) begin
      got.push_back(bus.tx_data);
      got_cyc.push_back(cyc);
      if (bus.tx_busy || prev_latch || cyc - fall_cyc < 2) viol <= viol + 1;
    end
    if (accept && bus.tx_latch) begin
      busy_r <= 1'b1;
      left <= frame_len - 1;
    end else if (busy_r) begin
      if (left == 0) begin
        busy_r <= 1'b0;
        fall_cyc <= cyc + 1;
      end else left <= left - 1;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.bus_addr = a;
    bus.bus_wdata = d;
    bus.bus_wr = 1'b1;
    tick;
    bus.bus_wr = 1'b0;
  endtask
  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.bus_addr = a;
    bus.bus_rd = 1'b1;
    tick;
    bus.bus_rd = 1'b0;
    d = bus.bus_rdata;
  endtask
  task automatic wait_latches(input int n, input int budget);
    int i = 0;
    while (got.size() < n && i < budget) begin
      tick;
      i++;
    end
    chk("latch_wait", 32'(got.size() >= n), 32'd1);
  endtask
  task automatic settle;
    int i = 0;
    while (busy_r && i < 200) begin
      tick;
      i++;
    end
    repeat (4) tick;
  endtask
  initial begin
    logic [7:0] d, b, f0, st;
    logic [7:0] exp_q[$];
    logic ovf;
    int base, k;
    bus.bus_addr = 2'd0;
    bus.bus_wdata = 8'd0;
    bus.bus_wr = 1'b0;
    bus.bus_rd = 1'b0;
    repeat (3) tick;
    chk("rst_rdata", bus.bus_rdata, 8'h00);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_tx_latch", bus.tx_latch, 1'b0);
    chk("rst_irq", bus.irq, 1'b0);
    rst = 1'b0;
    tick;
    rd(2'd1, d); chk("rst_status", d, 8'h01);
    rd(2'd2, d); chk("rst_control", d, 8'h01);
    rd(2'd0, d); chk("txdata_reads_zero", d, 8'h00);
    // single byte: write in N, latch with data in N+2
    bus.bus_addr = 2'd0;
    bus.bus_wdata = 8'h55;
    bus.bus_wr = 1'b1;
    tick;
    bus.bus_wr = 1'b0;
    chk("single_no_early_latch", bus.tx_latch, 1'b0);
    bus.bus_addr = 2'd1;
    bus.bus_rd = 1'b1;
    tick;
    bus.bus_rd = 1'b0;
    chk("single_latch", bus.tx_latch, 1'b1);
    chk("single_data", bus.tx_data, 8'h55);
    chk("single_status_count1", bus.bus_rdata, 8'h10);
    tick;
    chk("single_latch_one_cycle", bus.tx_latch, 1'b0);
    chk("single_busy_rises", bus.tx_busy, 1'b1);
    settle;
    rd(2'd1, d); chk("single_status_after", d, 8'h01);
    chk("irq_disabled", bus.irq, 1'b0);
    wr(2'd2, 8'h03);
    tick; tick;
    chk("irq_enabled_idle", bus.irq, 1'b1);
    // burst into a disabled controller overflows at DEPTH
    wr(2'd2, 8'h00);
    for (int i = 1; i <= 9; i++) wr(2'd0, 8'(i));
    rd(2'd1, d); chk("burst_status_ovf", d, 8'h8A);
    wr(2'd3, 8'h00);
    rd(2'd1, d); chk("burst_status_clear", d, 8'h82);
    base = got.size();
    frame_len = 5;
    wr(2'd2, 8'h01);
    wait_latches(base + 8, 400);
    settle;
    chk("burst_total", 32'(got.size()), 32'(base + 8));
    for (int i = 0; i < 8; i++) chk("burst_order", got[base + i], 8'(i + 1));
    chk("burst_protocol", 32'(viol), 32'd0);
    rd(2'd1, d); chk("burst_drained", d, 8'h01);
    // randomized rounds against a queue model
    for (int r = 0; r < 4; r++) begin
      wr(2'd2, 8'h00);
      k = $urandom_range(1, 11);
      exp_q.delete();
      ovf = 1'b0;
      for (int j = 0; j < k; j++) begin
        b = 8'($urandom);
        wr(2'd0, b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else ovf = 1'b1;
      end
      st = {4'(exp_q.size()), ovf, 1'b0, exp_q.size() == DEPTH, exp_q.size() == 0};
      rd(2'd1, d); chk("rand_status", d, st);
      wr(2'd3, 8'h00);
      frame_len = $urandom_range(2, 9);
      base = got.size();
      wr(2'd2, 8'h01);
      wait_latches(base + exp_q.size(), 600);
      settle;
      chk("rand_total", 32'(got.size()), 32'(base + exp_q.size()));
      for (int j = 0; j < exp_q.size(); j++) chk("rand_byte", got[base + j], exp_q[j]);
    end
    chk("rand_protocol", 32'(viol), 32'd0);
    // flush during the first frame of four queued bytes
    frame_len = 30;
    base = got.size();
    f0 = 8'($urandom);
    wr(2'd0, f0);
    for (int j = 0; j < 3; j++) wr(2'd0, 8'($urandom));
    wr(2'd2, 8'h81);
    settle;
    repeat (10) tick;
    chk("flush_one_frame", 32'(got.size()), 32'(base + 1));
    chk("flush_first_byte", got[base], f0);
    rd(2'd1, d); chk("flush_status", d, 8'h01);
    rd(2'd2, d); chk("flush_reads_zero", d, 8'h01);
    // transmitter never accepts: each load times out after four cycles
    accept = 1'b0;
    base = got.size();
    wr(2'd0, 8'hA5);
    wr(2'd0, 8'h3C);
    repeat (20) tick;
    chk("noacc_total", 32'(got.size()), 32'(base + 2));
    chk("noacc_first", got[base], 8'hA5);
    chk("noacc_second", got[base + 1], 8'h3C);
    chk("noacc_spacing", 32'(got_cyc[base + 1] - got_cyc[base]), 32'd6);
    rd(2'd1, d); chk("noacc_status", d, 8'h01);
    accept = 1'b1;
    // reset while a frame shifts with three bytes still queued
    frame_len = 25;
    base = got.size();
    for (int j = 0; j < 4; j++) wr(2'd0, 8'($urandom));
    tick;
    chk("rstmid_busy", bus.tx_busy, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstmid_latch", bus.tx_latch, 1'b0);
    chk("rstmid_tx_data", bus.tx_data, 8'h00);
    chk("rstmid_rdata", bus.bus_rdata, 8'h00);
    chk("rstmid_irq", bus.irq, 1'b0);
    rd(2'd1, d); chk("rstmid_status", d, 8'h05);
    rd(2'd2, d); chk("rstmid_control", d, 8'h01);
    settle;
    repeat (10) tick;
    chk("rstmid_no_latch", 32'(got.size()), 32'(base + 1));
    wr(2'd0, 8'h77);
    wait_latches(base + 2, 50);
    chk("rstmid_new_byte", got[base + 1], 8'h77);
    settle;
    chk("final_protocol", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
